// File: rtl/io_port_ctrl_if.sv
// Signal bundle between io_port_ctrl and its surroundings (register file, external I/O).
// Optional out_overflow appears when IO_OUT_OVERFLOW_EN is defined.
interface io_port_ctrl_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_DEPTH = 4
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;

    // Handshakes: a word moves on a clock edge where valid && ready are both high;
    // valid must not depend on ready, and the offered data is stable while valid waits.
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_valid;
    logic             ext_in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_data_write;
    logic             in_ack;
    logic             in_pending;
    logic [WIDTH-1:0] out_data;
    logic             out_push;
    logic             out_full;
    logic [CW-1:0]    out_count;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready;
    logic [1:0]       in_state;
`ifdef IO_OUT_OVERFLOW_EN
    logic             out_overflow;
`endif

    modport slave (
        input  ext_in_data, ext_in_valid, in_ack, out_data, out_push, ext_out_ready,
        output ext_in_ready, in_data, in_data_write, in_pending, out_full, out_count,
        output ext_out_data, ext_out_valid, in_state
`ifdef IO_OUT_OVERFLOW_EN
        , output out_overflow
`endif
    );

    modport master (
        output ext_in_data, ext_in_valid, in_ack, out_data, out_push, ext_out_ready,
        input  ext_in_ready, in_data, in_data_write, in_pending, out_full, out_count,
        input  ext_out_data, ext_out_valid, in_state
`ifdef IO_OUT_OVERFLOW_EN
        , input out_overflow
`endif
    );
endinterface

// File: rtl/io_port_ctrl.sv
// I/O port controller: input word capture into R13 with ack interlock, and an R14 output FIFO.
// Define IO_OUT_OVERFLOW_EN to add the sticky out_overflow flag for dropped pushes.
module io_port_ctrl #(
    parameter int WIDTH     = 16,
    parameter int OUT_DEPTH = 4
) (
    input logic           clock,
    input logic           reset_n,
    io_port_ctrl_if.slave bus
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);

    typedef enum logic [1:0] {
        IN_IDLE     = 2'd0,
        IN_WRITE    = 2'd1,
        IN_WAIT_ACK = 2'd2
    } in_state_t;

    in_state_t        state_q, state_d;
    logic [WIDTH-1:0] in_data_q;
    logic             capture;
    logic             write_strobe;
    logic             pending;

    // ---------------- input path ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IN_IDLE;
            in_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) in_data_q <= bus.ext_in_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        write_strobe = 1'b0;
        pending      = 1'b0;
        case (state_q)
            IN_IDLE: begin
                if (bus.ext_in_valid) begin
                    capture = 1'b1;
                    state_d = IN_WRITE;
                end
            end
            IN_WRITE: begin
                write_strobe = 1'b1;
                state_d      = bus.in_ack ? IN_IDLE : IN_WAIT_ACK;
            end
            IN_WAIT_ACK: begin
                pending = 1'b1;
                if (bus.in_ack) state_d = IN_IDLE;
            end
            default: state_d = IN_IDLE;
        endcase
    end

    // Strobes are gated so a reset cycle never shows a write or a pending word.
    assign bus.ext_in_ready  = (state_q == IN_IDLE) && reset_n;
    assign bus.in_data_write = write_strobe && reset_n;
    assign bus.in_pending    = pending && reset_n;
    assign bus.in_data       = in_data_q;
    assign bus.in_state      = state_q;

    // ---------------- output FIFO ----------------
    logic [WIDTH-1:0] mem [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic             fifo_valid, fifo_full, push, pop;

    assign fifo_valid = (count_q != '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = fifo_valid && bus.ext_out_ready;
    assign push       = bus.out_push && (!fifo_full || pop);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= bus.out_data;
    end

    // Head is registered so it holds the last popped word once the FIFO empties.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (count_q > CW'(1)) head_d = mem[rd_ptr_q + PW'(1)];
            else if (push)        head_d = bus.out_data;
        end else if (push && !fifo_valid) begin
            head_d = bus.out_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            head_q <= head_d;
        end
    end

    assign bus.out_count     = count_q;
    assign bus.out_full      = fifo_full;
    assign bus.ext_out_valid = fifo_valid;
    assign bus.ext_out_data  = head_q;

`ifdef IO_OUT_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clock) begin
        if (!reset_n)                                 overflow_q <= 1'b0;
        else if (bus.out_push && fifo_full && !pop)   overflow_q <= 1'b1;
    end

    assign bus.out_overflow = overflow_q;
`endif
endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: input capture/ack, FIFO fill/overflow, wrap and reset.
module tb_io_port_ctrl;
    localparam int WIDTH     = 16;
    localparam int OUT_DEPTH = 4;

    logic clock;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    io_port_ctrl_if #(.WIDTH(WIDTH), .OUT_DEPTH(OUT_DEPTH)) bus ();

    io_port_ctrl #(.WIDTH(WIDTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset_n           = 1'b0;
        bus.ext_in_data   = '0;
        bus.ext_in_valid  = 1'b0;
        bus.in_ack        = 1'b0;
        bus.out_data      = '0;
        bus.out_push      = 1'b0;
        bus.ext_out_ready = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_in_data", 32'(bus.in_data), 32'h0);
        check("rst_write", 32'(bus.in_data_write), 32'h0);
        check("rst_pending", 32'(bus.in_pending), 32'h0);
        check("rst_in_ready", 32'(bus.ext_in_ready), 32'h0);
        check("rst_count", 32'(bus.out_count), 32'h0);
        check("rst_full", 32'(bus.out_full), 32'h0);
        check("rst_out_valid", 32'(bus.ext_out_valid), 32'h0);
        check("rst_out_data", 32'(bus.ext_out_data), 32'h0);
        check("rst_state", 32'(bus.in_state), 32'h0);
        reset_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(bus.ext_in_ready), 32'h1);

        // single input word, held until acknowledged
        bus.ext_in_data  = 16'h00A5;
        bus.ext_in_valid = 1'b1;
        tick();
        bus.ext_in_valid = 1'b0;
        bus.ext_in_data  = 16'h5A5A;
        check("single_write", 32'(bus.in_data_write), 32'h1);
        check("single_data", 32'(bus.in_data), 32'h00A5);
        check("single_ready_busy", 32'(bus.ext_in_ready), 32'h0);
        tick();
        check("single_pending", 32'(bus.in_pending), 32'h1);
        check("single_ready_wait", 32'(bus.ext_in_ready), 32'h0);
        check("single_write_once", 32'(bus.in_data_write), 32'h0);
        tick();
        check("single_still_pending", 32'(bus.in_pending), 32'h1);
        bus.in_ack = 1'b1;
        tick();
        bus.in_ack = 1'b0;
        check("single_ready_after_ack", 32'(bus.ext_in_ready), 32'h1);
        check("single_not_pending", 32'(bus.in_pending), 32'h0);
        check("single_data_held", 32'(bus.in_data), 32'h00A5);

        // back-to-back input with ack tied high
        bus.in_ack       = 1'b1;
        bus.ext_in_data  = 16'd1;
        bus.ext_in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("b2b_write", 32'(bus.in_data_write), 32'h1);
            check("b2b_data", 32'(bus.in_data), 32'(k));
            if (k == 3) bus.ext_in_valid = 1'b0;
            else        bus.ext_in_data  = 16'(k + 1);
            tick();
            check("b2b_gap", 32'(bus.in_data_write), 32'h0);
            check("b2b_ready", 32'(bus.ext_in_ready), 32'h1);
        end
        tick();
        check("b2b_no_extra", 32'(bus.in_data_write), 32'h0);
        bus.in_ack = 1'b0;

        // empty FIFO with ready high: nothing happens
        bus.ext_out_ready = 1'b1;
        tick();
        bus.ext_out_ready = 1'b0;
        check("empty_pop_count", 32'(bus.out_count), 32'h0);
        check("empty_pop_valid", 32'(bus.ext_out_valid), 32'h0);

        // fill to full, fifth push dropped
        bus.out_push = 1'b1;
        bus.out_data = 16'h0011;
        tick();
        check("fill1_valid", 32'(bus.ext_out_valid), 32'h1);
        check("fill1_head", 32'(bus.ext_out_data), 32'h0011);
        check("fill1_count", 32'(bus.out_count), 32'h1);
        bus.out_data = 16'h0022;
        tick();
        bus.out_data = 16'h0033;
        tick();
        bus.out_data = 16'h0044;
        tick();
        check("fill4_full", 32'(bus.out_full), 32'h1);
        check("fill4_count", 32'(bus.out_count), 32'h4);
`ifdef IO_OUT_OVERFLOW_EN
        check("fill4_no_ovf", 32'(bus.out_overflow), 32'h0);
`endif
        bus.out_data = 16'h0055;
        tick();
        bus.out_push = 1'b0;
        check("drop_full", 32'(bus.out_full), 32'h1);
        check("drop_count", 32'(bus.out_count), 32'h4);
        check("drop_head_stable", 32'(bus.ext_out_data), 32'h0011);
`ifdef IO_OUT_OVERFLOW_EN
        check("drop_ovf", 32'(bus.out_overflow), 32'h1);
`endif

        // push and pop together at full
        bus.out_data      = 16'h0066;
        bus.out_push      = 1'b1;
        bus.ext_out_ready = 1'b1;
        tick();
        bus.out_push      = 1'b0;
        bus.ext_out_ready = 1'b0;
        check("pp_full_count", 32'(bus.out_count), 32'h4);
        check("pp_full_head", 32'(bus.ext_out_data), 32'h0022);
        tick();
        check("pp_head_stable", 32'(bus.ext_out_data), 32'h0022);

        // drain: dropped 55 must not appear
        check("drain0", 32'(bus.ext_out_data), 32'h0022);
        bus.ext_out_ready = 1'b1;
        tick();
        check("drain1", 32'(bus.ext_out_data), 32'h0033);
        tick();
        check("drain2", 32'(bus.ext_out_data), 32'h0044);
        tick();
        check("drain3", 32'(bus.ext_out_data), 32'h0066);
        check("drain3_count", 32'(bus.out_count), 32'h1);
        tick();
        bus.ext_out_ready = 1'b0;
        check("drained_valid", 32'(bus.ext_out_valid), 32'h0);
        check("drained_count", 32'(bus.out_count), 32'h0);
        check("drained_hold", 32'(bus.ext_out_data), 32'h0066);
`ifdef IO_OUT_OVERFLOW_EN
        check("ovf_sticky", 32'(bus.out_overflow), 32'h1);
`endif

        // push and pop together at count 1
        bus.out_data = 16'h0A0A;
        bus.out_push = 1'b1;
        tick();
        bus.out_data      = 16'h0B0B;
        bus.ext_out_ready = 1'b1;
        tick();
        bus.out_push      = 1'b0;
        check("pp1_count", 32'(bus.out_count), 32'h1);
        check("pp1_head", 32'(bus.ext_out_data), 32'h0B0B);
        tick();
        bus.ext_out_ready = 1'b0;
        check("pp1_empty", 32'(bus.ext_out_valid), 32'h0);

        // pointer wrap: interleaved push/pop of 0..9
        for (int i = 0; i < 10; i++) begin
            bus.out_data = 16'(i);
            bus.out_push = 1'b1;
            tick();
            bus.out_push = 1'b0;
            check("wrap_head", 32'(bus.ext_out_data), 32'(i));
            check("wrap_valid", 32'(bus.ext_out_valid), 32'h1);
            bus.ext_out_ready = 1'b1;
            tick();
            bus.ext_out_ready = 1'b0;
            check("wrap_empty", 32'(bus.ext_out_valid), 32'h0);
        end

        // reset mid-operation: 3 words queued, input waiting for ack
        bus.out_push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.out_data = 16'(16'h0100 + i);
            tick();
        end
        bus.out_push     = 1'b0;
        bus.ext_in_data  = 16'h0077;
        bus.ext_in_valid = 1'b1;
        tick();
        bus.ext_in_valid = 1'b0;
        tick();
        check("pre_rst_count", 32'(bus.out_count), 32'h3);
        check("pre_rst_pending", 32'(bus.in_pending), 32'h1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_count", 32'(bus.out_count), 32'h0);
        check("mid_rst_valid", 32'(bus.ext_out_valid), 32'h0);
        check("mid_rst_pending", 32'(bus.in_pending), 32'h0);
        check("mid_rst_write", 32'(bus.in_data_write), 32'h0);
        check("mid_rst_out_data", 32'(bus.ext_out_data), 32'h0);
        check("mid_rst_in_data", 32'(bus.in_data), 32'h0);
`ifdef IO_OUT_OVERFLOW_EN
        check("mid_rst_ovf", 32'(bus.out_overflow), 32'h0);
`endif
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus.ext_in_ready), 32'h1);
        check("post_rst_full", 32'(bus.out_full), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
